// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage.
//   - wb_sel_e : write-back source select encodings (WB_ALU/WB_MEM/WB_PC4/WB_IMM)
//   - LD_*     : load funct3 size/sign codes
//   - wb_reg_t : contents of the WB pipeline register
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    // A bubble is simply valid=0, reg_write=0; the other fields are then
    // don't-care and are loaded as zero.
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        wb_sel_e     wb_sel;
        logic [2:0]  funct3;
        logic [1:0]  addr_low;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [31:0] imm;
    } wb_reg_t;

endpackage

// File: rtl/load_ext.sv
// load_ext: combinational byte/half extraction and sign/zero extension of a
// loaded memory word. Only compiled when WB_LOAD_EXT_EN is defined; in the
// default build this file is intentionally empty.
//   memIn     in  32  raw aligned memory word
//   funct3In  in  3   load size/sign code (LD_* from wb_pkg)
//   addrLowIn in  2   byte address bits [1:0]
//   dataOut   out 32  extended load value
`ifdef WB_LOAD_EXT_EN
module load_ext
    import wb_pkg::*;
(
    input  logic [31:0] memIn,
    input  logic [2:0]  funct3In,
    input  logic [1:0]  addrLowIn,
    output logic [31:0] dataOut
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = memIn[7:0];
        case (addrLowIn)
            2'd0:    byte_sel = memIn[7:0];
            2'd1:    byte_sel = memIn[15:8];
            2'd2:    byte_sel = memIn[23:16];
            default: byte_sel = memIn[31:24];
        endcase
        // Halfword loads ignore address bit 0.
        half_sel = addrLowIn[1] ? memIn[31:16] : memIn[15:0];

        dataOut = memIn;
        case (funct3In)
            LD_B:    dataOut = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    dataOut = {{16{half_sel[15]}}, half_sel};
            LD_BU:   dataOut = {24'd0, byte_sel};
            LD_HU:   dataOut = {16'd0, half_sel};
            default: dataOut = memIn;  // LW and unknown codes
        endcase
    end

endmodule
`endif

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage. Registers the MA result, selects the
// write-back source and drives the register file write port; the same value
// is exposed for forwarding. Also counts retired instructions.
// Optional feature macro: WB_LOAD_EXT_EN (byte/half load extraction).
// Ports:
//   clkIn, resetIn (async active-low)
//   validIn/stallIn/flushIn  MA stage status; an instruction moves to WB only
//                            when validIn=1 and neither stallIn nor flushIn
//   regWriteIn, rdIn, wbSelIn, aluIn, memIn, pcIn, immIn, funct3In, addrLowIn
//   rdOut, dataOut, writeOut  register file write port (also forwarding)
//   retireOut, retireCountOut retire pulse and 32-bit wrapping count
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clkIn,
    input  logic            resetIn,
    input  logic            validIn,
    input  logic            stallIn,
    input  logic            flushIn,
    input  logic            regWriteIn,
    input  logic [4:0]      rdIn,
    input  logic [1:0]      wbSelIn,
    input  logic [XLEN-1:0] aluIn,
    input  logic [XLEN-1:0] memIn,
    input  logic [XLEN-1:0] pcIn,
    input  logic [XLEN-1:0] immIn,
    input  logic [2:0]      funct3In,
    input  logic [1:0]      addrLowIn,
    output logic [4:0]      rdOut,
    output logic [XLEN-1:0] dataOut,
    output logic            writeOut,
    output logic            retireOut,
    output logic [XLEN-1:0] retireCountOut
);

    wb_reg_t     wb_d, wb_q;
    logic [31:0] retire_count_d, retire_count_q;
    logic [31:0] mem_ext;

    // A stalled MA instruction is held upstream, so WB takes a bubble while
    // stalled and commits the instruction once, on the cycle it leaves MA.
    always_comb begin
        wb_d = '0;
        if (validIn && !stallIn && !flushIn) begin
            wb_d.valid     = 1'b1;
            wb_d.reg_write = regWriteIn;
            wb_d.rd        = rdIn;
            wb_d.wb_sel    = wb_sel_e'(wbSelIn);
            wb_d.funct3    = funct3In;
            wb_d.addr_low  = addrLowIn;
            wb_d.alu       = aluIn;
            wb_d.mem       = memIn;
            wb_d.pc4       = pcIn + 32'd4;  // wraps modulo 2^32
            wb_d.imm       = immIn;
        end
    end

    always_comb begin
        retire_count_d = retire_count_q + {31'd0, wb_q.valid};
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            wb_q           <= '0;
            retire_count_q <= '0;
        end else begin
            wb_q           <= wb_d;
            retire_count_q <= retire_count_d;
        end
    end

`ifdef WB_LOAD_EXT_EN
    load_ext u_load_ext (
        .memIn     (wb_q.mem),
        .funct3In  (wb_q.funct3),
        .addrLowIn (wb_q.addr_low),
        .dataOut   (mem_ext)
    );
`else
    // Load size/offset are carried but not used when extraction is disabled.
    logic unused_ld;
    assign unused_ld = ^{wb_q.funct3, wb_q.addr_low};
    assign mem_ext   = wb_q.mem;
`endif

    // All outputs depend only on the WB register: no input-to-output paths.
    always_comb begin
        dataOut = wb_q.alu;
        case (wb_q.wb_sel)
            WB_ALU:  dataOut = wb_q.alu;
            WB_MEM:  dataOut = mem_ext;
            WB_PC4:  dataOut = wb_q.pc4;
            WB_IMM:  dataOut = wb_q.imm;
            default: dataOut = wb_q.alu;
        endcase
    end

    assign rdOut          = wb_q.rd;
    assign writeOut       = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);
    assign retireOut      = wb_q.valid;
    assign retireCountOut = retire_count_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the pipeline: the producer side of the register file write port. It registers the memory-access stage result, selects and extends the write-back value, and drives the register file's `rdIn`/`dataIn`/`writeIn`. It also exposes the same value for forwarding and counts retired instructions.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. Only 32 is supported.

Ports:
- `clkIn`  in  1  clock; all state updates on the rising edge.
- `resetIn`  in  1  reset, asynchronous, active-low.
- `validIn`  in  1  MA stage holds a real instruction.
- `stallIn`  in  1  MA stage frozen this cycle.
- `flushIn`  in  1  kill the MA instruction.
- `regWriteIn`  in  1  instruction writes `rd`.
- `rdIn`  in  5  destination register index.
- `wbSelIn`  in  2  source select: 0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate.
- `aluIn`, `memIn`, `pcIn`, `immIn`  in  32 each  candidate values; `pcIn` is the instruction's own PC.
- `funct3In`  in  3  load size/sign code.
- `addrLowIn`  in  2  load address bits [1:0].
- `rdOut`  out  5  to register file `rdIn`.
- `dataOut`  out  32  to register file `dataIn`, and forwarding data.
- `writeOut`  out  1  to register file `writeIn`.
- `retireOut`  out  1  a valid instruction is in WB this cycle.
- `retireCountOut`  out  32  retired-instruction count.

## Operation
- One WB pipeline register holds: valid, regWrite, rd, wbSel, funct3, addrLow, and the four 32-bit values. `pcIn + 4` is computed before capture.
- Capture rule on each edge:
  - If `flushIn`, `stallIn`, or `!validIn` is high: load a bubble (valid=0, regWrite=0). Other fields are don't-care.
  - Otherwise: load the MA fields.
  - `flushIn` and `stallIn` high together: bubble. A frozen MA instruction is therefore committed exactly once, on the cycle it leaves MA.
- `writeOut = valid & regWrite & (rd != 0)`. x0 is never written.
- `dataOut` is selected by wbSel:
  - ALU: `aluIn`.
  - memory: the load-extended word (see Configuration).
  - PC+4: stored value, wraps modulo 2^32 (0xFFFFFFFC → 0).
  - immediate: `immIn`.
- `rdOut` is the registered rd. `retireOut` is the registered valid.
- Retire counter:
  - Increments by 1 on every edge where the registered valid is 1, independent of regWrite.
  - Wraps 0xFFFFFFFF → 0.

## Timing
- Latency is 1 cycle: MA inputs sampled at edge N appear on the outputs after edge N, and the register file writes them at edge N+1.
- `dataOut`, `writeOut` and `rdOut` are combinational from the WB register only. There are no combinational paths from any input.
- Reset assertion, at any time including mid-stall, asynchronously sets:
  - valid=0, so `writeOut=0` and `retireOut=0`;
  - `rdOut=0`, `dataOut=0`, `retireCountOut=0`;
  - all stored fields to 0.
- The first capture happens on the first rising edge after reset deassertion.
- Back-to-back valid instructions give one write per cycle with no bubbles.

## Configuration
- `WB_LOAD_EXT_EN` defined: memory-source data goes through byte/half extraction, selected by `funct3In`:
  - 000 LB: byte `addrLow`, sign-extended.
  - 001 LH: half selected by `addrLow[1]`, sign-extended; `addrLow[0]` ignored.
  - 010 LW: word.
  - 100 LBU: byte `addrLow`, zero-extended.
  - 101 LHU: half selected by `addrLow[1]`, zero-extended.
  - any other code: word passed through.
- `WB_LOAD_EXT_EN` undefined: memory-source data is `memIn` unchanged. `funct3In` and `addrLowIn` remain as ports but are ignored, and their register bits may be optimized away.

## Structure
- Shared package `wb_pkg`:
  - wbSel encodings `WB_ALU`, `WB_MEM`, `WB_PC4`, `WB_IMM`;
  - load funct3 constants `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU`.
- Sub-module `load_ext`: combinational extractor with inputs `memIn`, `funct3In`, `addrLowIn` and output a 32-bit word. Instantiated only under `WB_LOAD_EXT_EN`.

## Test plan
- Reset, then one ALU instruction with rd=5, aluIn=0x12345678, regWrite=1 → the next cycle shows writeOut=1, rdOut=5, dataOut=0x12345678, retireCountOut 0 → 1 after the following edge.
- Instruction with rd=0 and regWrite=1 → writeOut=0, retireOut=1, and the counter still increments.
- stallIn=1 for 3 cycles with validIn=1, then released → exactly one writeOut pulse and the counter increases by 1 total. flushIn together with stallIn → no write.
- With `WB_LOAD_EXT_EN`, memIn=0x80FF7F01:
  - LB at addrLow=2 → 0xFFFFFFFF;
  - LBU at addrLow=3 → 0x00000080;
  - LH at addrLow=0 → 0x00007F01;
  - LHU at addrLow=2 → 0x000080FF.
  Without the macro, every case → 0x80FF7F01.
- PC+4 select with pcIn=0xFFFFFFFC → dataOut=0. Preload the counter to 0xFFFFFFFF via a forced value and retire one instruction → 0.
- Reset asserted asynchronously mid-cycle while writeOut=1 → writeOut, dataOut and retireCountOut go to 0 before the next clock edge.
